rgb_fade_sequencer: RTL
=======================

Name:
rgb_fade_sequencer

Overview:
Command-driven effect controller for the RGB PWM path. It accepts colour/effect commands over a valid/ready handshake and produces per-channel 4-bit brightness levels. Those levels feed one gamma LUT per channel, and the LUT outputs feed the PWM duty inputs. It replaces the hard-wired purple breathing in the top level with SET, FADE, BREATHE and OFF effects, all paced by the shared PWM tick.

Parameters:
- STEP_DIV, 30, number of tick pulses per animation step; legal range 1..255.
- LVL_W, 4, brightness level width; the gamma LUT index is fixed at 4, so LVL_W is 4.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tick  in  1  single-cycle PWM step strobe from tick_gen
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_mode  in  2  0=SET, 1=FADE, 2=BREATHE, 3=OFF
- cmd_r  in  4  red target level
- cmd_g  in  4  green target level
- cmd_b  in  4  blue target level
- lvl_r  out  4  red level to gamma LUT (registered)
- lvl_g  out  4  green level to gamma LUT (registered)
- lvl_b  out  4  blue level to gamma LUT (registered)
- busy  out  1  high in FADE state
- done  out  1  one-cycle pulse when a SET, FADE or OFF completes

Behaviour:
- Clock and reset: clk rising edge; rst_n asynchronous, active-low.
- Reset values: lvl_* = 0, targets = 0, state = IDLE, cmd_ready = 1, busy = 0, done = 0, step divider = 0, envelope = 0, envelope direction = up.
- Accept: a command is accepted when cmd_valid && cmd_ready on a rising edge. The targets tgt_r/g/b are latched on that same edge.
- Step strobe: asserted for one cycle when tick = 1 and div == STEP_DIV-1.
  - On the strobe, div returns to 0.
  - On other cycles with tick = 1, div increments.
  - With tick = 0, div holds.
  - div clears on every accept.
- States: IDLE, FADE, BREATHE.
- IDLE:
  - cmd_ready = 1.
  - SET: lvl_* take the targets on the accept edge; done pulses the next cycle; state stays IDLE.
  - FADE: go to FADE.
  - OFF: behaves as FADE with targets forced to 0,0,0.
  - BREATHE: go to BREATHE with envelope = 0 and direction = up.
- FADE:
  - cmd_ready = 0, busy = 1.
  - On each step strobe, every channel moves toward its target by 1; channels already at target hold.
  - Combinational check in FADE: when all lvl_* == tgt_*, go to IDLE on the next edge with a one-cycle done pulse.
  - Consequence: a FADE whose targets equal the current levels completes one cycle after accept, with zero steps.
- BREATHE:
  - cmd_ready = 1, busy = 0, done never pulses.
  - Envelope env (0..15) advances one per step strobe as a triangle wave:
    - Counting up, at 15 it flips to down and goes to 14.
    - Counting down, at 0 it flips to up and goes to 1.
  - Each cycle, lvl_x <= (tgt_x * (env+1)) >> 4, using an 8-bit product. So env = 15 gives tgt_x, and env = 0 gives 0.
  - An accepted command leaves BREATHE immediately. A FADE or OFF then starts from the current lvl_* values, with no jump.
- Reset mid-operation: all state returns to reset values immediately, asynchronously.
- No command is lost and none is double-accepted. A command presented while cmd_ready = 0 must be held by the sender.

Optional Feature:
- Macro: SEQ_CMD_BUF_EN.
- Defined: a one-entry command buffer is added.
  - In FADE, cmd_ready = 1 while the buffer is empty, and an accept fills the buffer.
  - On FADE completion, the buffered command is taken instead of entering IDLE. This happens on the same edge as the done pulse, so no idle cycle occurs.
  - Reset empties the buffer.
- Not defined: cmd_ready = 0 throughout FADE, exactly as specified above.

Decomposition:
- Package rgb_seq_pkg:
  - mode encodings MODE_SET/MODE_FADE/MODE_BREATHE/MODE_OFF;
  - state encodings ST_IDLE/ST_FADE/ST_BREATHE;
  - LVL_W = 4 and ENV_MAX = 15.
- Sub-module breathe_env: contains the step divider, the step strobe output, and the triangle envelope counter plus direction. Inputs: clk, rst_n, tick, clear, run. Outputs: step, env[3:0].

Test Plan:
Bench setup for all scenarios: STEP_DIV = 2, tick tied to 1.
1. Reset, then release -> lvl = 0,0,0; cmd_ready = 1; busy = 0; done = 0.
2. SET (15,0,7) -> lvl = F,0,7 one cycle after accept; done is high for exactly 1 cycle; busy stays 0.
3. FADE from (15,0,7) to (0,3,7):
   - r decrements once every 2 cycles;
   - g reaches 3 after 3 steps and holds;
   - done pulses once after step 15;
   - cmd_ready = 0 during the fade; a held cmd_valid is accepted only after done.
4. BREATHE (8,0,8):
   - lvl_r reads 8 at env = 15 and 4 at env = 7; g stays 0;
   - the envelope sequence is ...14,15,14... and ...1,0,1...;
   - an OFF issued at env = 10 ramps down from 5 with no jump, then done pulses.
5. Tick gating: during a fade, hold tick = 0 for 100 cycles -> lvl frozen and div holds; normal stepping resumes when tick returns.
6. Reset asserted mid-FADE -> all outputs are 0 and IDLE immediately. With SEQ_CMD_BUF_EN: a second SET issued during a FADE is accepted, and lvl takes its value on the cycle done pulses.

Source files
------------

// File: rtl/rgb_seq_pkg.sv
// rgb_seq_pkg: shared encodings and helpers for the RGB fade sequencer.
package rgb_seq_pkg;
    localparam int LVL_W = 4;
    localparam int ENV_MAX = 15;

    localparam logic [1:0] MODE_SET = 2'd0;
    localparam logic [1:0] MODE_FADE = 2'd1;
    localparam logic [1:0] MODE_BREATHE = 2'd2;
    localparam logic [1:0] MODE_OFF = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FADE = 2'd1;
    localparam logic [1:0] ST_BREATHE = 2'd2;

    typedef struct packed {
        logic [1:0] mode;
        logic [LVL_W-1:0] r;
        logic [LVL_W-1:0] g;
        logic [LVL_W-1:0] b;
    } cmd_t;

    function automatic logic [LVL_W-1:0] toward(input logic [LVL_W-1:0] cur, input logic [LVL_W-1:0] tgt);
        return cur < tgt ? cur + 1'b1 : cur > tgt ? cur - 1'b1 : cur;
    endfunction

    // (tgt * (env+1)) >> 4 with an 8-bit product: env=15 yields tgt, env=0 yields tgt/16
    function automatic logic [LVL_W-1:0] scale(input logic [LVL_W-1:0] tgt, input logic [3:0] env);
        logic [7:0] p;
        p = {4'b0, tgt} * ({4'b0, env} + 8'd1);
        return p[7:4];
    endfunction
endpackage

// File: rtl/rgb_fade_sequencer_env.sv
// breathe_env: tick-paced step divider plus triangle envelope counter.
module breathe_env
    import rgb_seq_pkg::*;
#(
    parameter int STEP_DIV = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       clear,
    input  logic       run,
    output logic       step,
    output logic [3:0] env
);
    logic [7:0] div;
    logic       dn;

    assign step = tick && div == 8'(STEP_DIV - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
            env <= '0;
            dn  <= 1'b0;
        end else if (clear) begin
            div <= '0;
            env <= '0;
            dn  <= 1'b0;
        end else begin
            if (tick) div <= step ? '0 : div + 8'd1;
            if (step && run) begin
                if (dn ? env == 4'd0 : env == 4'(ENV_MAX)) begin
                    dn  <= !dn;
                    env <= dn ? 4'd1 : 4'(ENV_MAX - 1);
                end else begin
                    env <= dn ? env - 4'd1 : env + 4'd1;
                end
            end
        end
    end
endmodule

// File: rtl/rgb_fade_sequencer.sv
// rgb_fade_sequencer: SET/FADE/BREATHE/OFF colour effects feeding the gamma LUTs.
// Define SEQ_CMD_BUF_EN to add a one-entry command buffer usable during FADE.
module rgb_fade_sequencer
    import rgb_seq_pkg::*;
#(
    parameter int STEP_DIV = 30
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [LVL_W-1:0] cmd_r,
    input  logic [LVL_W-1:0] cmd_g,
    input  logic [LVL_W-1:0] cmd_b,
    output logic [LVL_W-1:0] lvl_r,
    output logic [LVL_W-1:0] lvl_g,
    output logic [LVL_W-1:0] lvl_b,
    output logic             busy,
    output logic             done
);
    logic [1:0]       state;
    logic [LVL_W-1:0] tgt_r, tgt_g, tgt_b;
    logic             step;
    logic [3:0]       env;
    logic             accept, fade_done, take, apply;
    cmd_t             in_cmd, nxt_cmd;

    assign in_cmd    = {cmd_mode, cmd_r, cmd_g, cmd_b};
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = state == ST_FADE;
    assign fade_done = busy && {lvl_r, lvl_g, lvl_b} == {tgt_r, tgt_g, tgt_b};
    assign apply     = (accept && !busy) || take;

`ifdef SEQ_CMD_BUF_EN
    cmd_t buf_cmd;
    logic buf_full;

    assign cmd_ready = !busy || !buf_full;
    // a command arriving on the completing cycle bypasses the buffer
    assign take      = fade_done && (buf_full || accept);
    assign nxt_cmd   = buf_full ? buf_cmd : in_cmd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_full <= 1'b0;
            buf_cmd  <= '0;
        end else if (take) begin
            buf_full <= 1'b0;
        end else if (accept && busy) begin
            buf_full <= 1'b1;
            buf_cmd  <= in_cmd;
        end
    end
`else
    assign cmd_ready = !busy;
    assign take      = 1'b0;
    assign nxt_cmd   = in_cmd;
`endif

    breathe_env #(.STEP_DIV(STEP_DIV)) u_env (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick),
        .clear(apply),
        .run  (state == ST_BREATHE),
        .step (step),
        .env  (env)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            {tgt_r, tgt_g, tgt_b} <= '0;
            {lvl_r, lvl_g, lvl_b} <= '0;
            done <= 1'b0;
        end else begin
            done <= (apply && nxt_cmd.mode == MODE_SET) || fade_done;
            if (apply) begin
                {tgt_r, tgt_g, tgt_b} <= nxt_cmd.mode == MODE_OFF ? '0 : {nxt_cmd.r, nxt_cmd.g, nxt_cmd.b};
                state <= nxt_cmd.mode == MODE_SET ? ST_IDLE : nxt_cmd.mode == MODE_BREATHE ? ST_BREATHE : ST_FADE;
                if (nxt_cmd.mode == MODE_SET) {lvl_r, lvl_g, lvl_b} <= {nxt_cmd.r, nxt_cmd.g, nxt_cmd.b};
            end else if (fade_done) begin
                state <= ST_IDLE;
            end else if (busy && step) begin
                lvl_r <= toward(lvl_r, tgt_r);
                lvl_g <= toward(lvl_g, tgt_g);
                lvl_b <= toward(lvl_b, tgt_b);
            end else if (state == ST_BREATHE) begin
                lvl_r <= scale(tgt_r, env);
                lvl_g <= scale(tgt_g, env);
                lvl_b <= scale(tgt_b, env);
            end
        end
    end
endmodule
